// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package arb_pkg;

    // Widest one-hot vector onehot_to_bin can encode.
    localparam int ARB_MAX_W = 64;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Binary index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic int onehot_to_bin(input logic [ARB_MAX_W-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_W; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_lsb_pick.sv
// Combinational lowest-set-bit picker: one-hot of the lowest set bit of req, zero if none.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module arb_lsb_pick #(
    parameter int REQ_WIDTH = 8
) (
    input  logic [REQ_WIDTH-1:0] req,
    output logic [REQ_WIDTH-1:0] pick
);

    // Walk upward; the first set bit wins and blocks every bit above it.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (req[i] && !found) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_hold.sv
// Registered round-robin arbiter: the owner holds the grant while requesting, then rotation moves on.
// Latency: 1 cycle req->gnt from idle; owner release hands over at the same edge (no bubble).
// Backpressure: none; ARB_RR_BURST_LIMIT_EN caps a contested hold at MAX_BURST cycles.
module arbiter_rr_hold
    import arb_pkg::*;
#(
    parameter int  REQ_WIDTH = 8,
    parameter int  MAX_BURST = 4,
    localparam int ID_W      = clog2_min1(REQ_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REQ_WIDTH-1:0] req,
    output logic [REQ_WIDTH-1:0] gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 busy
);

    if (REQ_WIDTH < 1 || MAX_BURST < 1) begin : g_bad_params
        $error("arbiter_rr_hold: REQ_WIDTH and MAX_BURST must be >= 1");
    end

    arb_state_t           state;
    logic [REQ_WIDTH-1:0] mask;
    logic [REQ_WIDTH-1:0] req_elig;
    logic [REQ_WIDTH-1:0] req_masked;
    logic [REQ_WIDTH-1:0] pick_masked;
    logic [REQ_WIDTH-1:0] pick_any;
    logic [REQ_WIDTH-1:0] pick;
    logic [REQ_WIDTH-1:0] pick_mask;
    logic [ID_W-1:0]      pick_id;
    logic                 keep;
    logic                 expire;

    // The current owner is never a candidate for the next grant; in idle gnt is zero.
    assign req_elig   = req & ~gnt;
    assign req_masked = req_elig & mask;
    assign keep       = |(req & gnt);

    arb_lsb_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick_masked (
        .req  (req_masked),
        .pick (pick_masked)
    );

    arb_lsb_pick #(.REQ_WIDTH(REQ_WIDTH)) u_pick_any (
        .req  (req_elig),
        .pick (pick_any)
    );

    // Prefer requesters above the last grant; otherwise wrap to the lowest one.
    assign pick    = (|req_masked) ? pick_masked : pick_any;
    assign pick_id = ID_W'(onehot_to_bin(ARB_MAX_W'(pick)));

    // Mask for the next round: bits strictly above the new owner, all ones after the top bit.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        pick_mask = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            pick_mask[i] = seen;
            seen         = seen | pick[i];
        end
        if (pick_mask == '0) pick_mask = '1;
    end

`ifdef ARB_RR_BURST_LIMIT_EN
    localparam int CNT_W = clog2_min1(MAX_BURST);
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_last;

    // Owner has used its last allowed cycle and someone else is waiting.
    assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign expire     = burst_last && (|req_elig);
`else
    assign expire = 1'b0;
`endif

    // Arbitration FSM: state, grant outputs and rotation mask update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB_IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            mask   <= '1;
`ifdef ARB_RR_BURST_LIMIT_EN
            burst_cnt <= '0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state  <= ARB_GRANT;
                        gnt    <= pick;
                        gnt_id <= pick_id;
                        busy   <= 1'b1;
                        mask   <= pick_mask;
`ifdef ARB_RR_BURST_LIMIT_EN
                        burst_cnt <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    if (keep && !expire) begin
`ifdef ARB_RR_BURST_LIMIT_EN
                        burst_cnt <= burst_last ? '0 : burst_cnt + 1'b1;
`endif
                    end else if (|req_elig) begin
                        gnt    <= pick;
                        gnt_id <= pick_id;
                        mask   <= pick_mask;
`ifdef ARB_RR_BURST_LIMIT_EN
                        burst_cnt <= '0;
`endif
                    end else begin
                        state  <= ARB_IDLE;
                        gnt    <= '0;
                        gnt_id <= '0;
                        busy   <= 1'b0;
`ifdef ARB_RR_BURST_LIMIT_EN
                        burst_cnt <= '0;
`endif
                    end
                end
                default: begin
                    state  <= ARB_IDLE;
                    gnt    <= '0;
                    gnt_id <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// Bench for arbiter_rr_hold: index-based round-robin model plus directed literal checks.
// Latency: checks sample at the falling edge after each rising edge.
// Backpressure: n/a.
module tb_arbiter_rr_hold;

    localparam int W         = 8;
    localparam int MAX_BURST = 4;
`ifdef ARB_RR_BURST_LIMIT_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] req = '0;
    logic [W-1:0] gnt;
    logic [2:0]   gnt_id;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    arbiter_rr_hold #(.REQ_WIDTH(W), .MAX_BURST(MAX_BURST)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- model: owner index, pointer to last granted index ----------------
    int m_owner = -1;   // -1: nobody holds the grant
    int m_ptr   = -1;   // search starts at m_ptr+1; -1 means start from requester 0
    int m_held  = 0;    // cycles the current owner has held the grant

    function automatic int model_pick(input logic [W-1:0] r, input int excl, input int ptr);
        for (int i = ptr + 1; i < W; i++) if (r[i] && i != excl) return i;
        for (int i = 0; i < W; i++) if (r[i] && i != excl) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int  nxt;
        bit  others;
        bit  force_rel;
        if (rst) begin
            m_owner = -1;
            m_ptr   = -1;
            m_held  = 0;
        end else begin
            others = 1'b0;
            for (int i = 0; i < W; i++) if (req[i] && i != m_owner) others = 1'b1;
            force_rel = BURST_EN && (m_owner >= 0) && (m_held == MAX_BURST) && others;
            if (m_owner >= 0 && req[m_owner] && !force_rel) begin
                m_held = (BURST_EN && m_held == MAX_BURST) ? 1 : m_held + 1;
            end else begin
                nxt = model_pick(req, m_owner, m_ptr);
                if (nxt >= 0) begin
                    m_owner = nxt;
                    m_ptr   = (nxt == W - 1) ? -1 : nxt;
                    m_held  = 1;
                end else begin
                    m_owner = -1;
                end
            end
        end
    end

    // Compare process: model vs DUT plus structural invariants, every cycle out of reset.
    always @(negedge clk) begin : compare
        logic [W-1:0] exp_gnt;
        int           idx;
        if (!rst) begin
            exp_gnt = (m_owner >= 0) ? (W'(1) << m_owner) : '0;
            check("model_gnt", 32'(gnt), 32'(exp_gnt));
            check("model_gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            check("model_busy", 32'(busy), 32'(m_owner >= 0));
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            idx = 0;
            for (int i = 0; i < W; i++) if (gnt[i]) idx = i;
            check("gnt_id_index", 32'(gnt_id), 32'(idx));
        end
    end

    // Apply a request vector for exactly one rising edge; returns at the following falling edge.
    task automatic step(input logic [W-1:0] r);
        req = r;
        @(negedge clk);
    endtask

    logic [W-1:0] order [9];

    initial begin
        order = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

        // Reset state
        @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_gnt_id", 32'(gnt_id), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        // Basic hold / rotate
        step(8'h05);
        check("basic_first", 32'(gnt), 32'h01);
        step(8'h05);
        check("basic_hold", 32'(gnt), 32'h01);
        step(8'h04);
        check("basic_rotate", 32'(gnt), 32'h04);
        check("basic_rotate_id", 32'(gnt_id), 32'd2);
        step(8'h00);
        check("basic_idle_gnt", 32'(gnt), 32'h0);
        check("basic_idle_busy", 32'(busy), 32'h0);

        // Async reset mid-grant
        step(8'h04);
        check("pre_reset_gnt", 32'(gnt), 32'h04);
        req = 8'hFF;
        #2 rst = 1'b1;
        #1;
        check("async_reset_gnt", 32'(gnt), 32'h0);
        check("async_reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(8'hFF);
        check("post_reset_gnt", 32'(gnt), 32'h01);

        // Fairness wrap: each owner drops for one cycle after two granted cycles
        for (int k = 0; k < 9; k++) begin
            check("wrap_first", 32'(gnt), 32'(order[k]));
            step(8'hFF);
            check("wrap_second", 32'(gnt), 32'(order[k]));
            step(8'hFF & ~order[k]);
        end
        step(8'h00);
        check("wrap_idle", 32'(gnt), 32'h0);

        // Simultaneous release and new requests: above-pointer requester wins
        step(8'h10);
        check("simul_owner", 32'(gnt), 32'h10);
        step(8'h42);
        check("simul_above", 32'(gnt), 32'h40);
        step(8'h02);
        check("simul_wrap", 32'(gnt), 32'h02);
        step(8'h00);
        check("simul_idle", 32'(gnt), 32'h0);

        // Two constant requesters
        if (BURST_EN) begin
            for (int n = 0; n < 12; n++) begin
                step(8'h03);
                check("burst_seq", 32'(gnt), ((n / 4) % 2 == 0) ? 32'h01 : 32'h02);
            end
        end else begin
            for (int n = 0; n < 100; n++) begin
                step(8'h03);
                check("hold_100", 32'(gnt), 32'h01);
            end
        end

        // Lone requester keeps the grant indefinitely
        for (int n = 0; n < 10; n++) begin
            step(8'h01);
            check("lone_hold", 32'(gnt), 32'h01);
        end
        step(8'h00);
        check("final_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
